mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the keyboard code FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter OFFSET_ADDR, default 0, giving the word address of the sprite offset word.
REQ-003 SHALL have parameter KB_DATA_ADDR, default 1, giving the word address of the keyboard mailbox word.
REQ-004 SHALL have parameter KB_STAT_ADDR, default 2, giving the word address of the keyboard status word (not RAM-backed).
REQ-005 SHALL have ports, in this order:
 clk  in  1  sole clock; all state updates on its rising edge.
 reset  in  1  asynchronous, active-low reset.
 cpu_addr  in  32  CPU byte address; bits [6:2] select the word.
 cpu_we  in  1  CPU write request.
 cpu_re  in  1  CPU read request.
 cpu_wdata  in  32  CPU write data.
 cpu_rdata  out  32  CPU read data, combinational.
 kb_valid  in  1  keyboard code offered.
 kb_code  in  8  scancode.
 kb_ready  out  1  FIFO can accept a code.
 vsync  in  1  frame sync from the VGA controller, clk domain.
 disp_offset  out  10  offset snapshot for the sprite mux.
 disp_valid  out  1  snapshot taken since reset.
 mem_we  out  1  RAM write enable.
 mem_addr  out  5  RAM word address.
 mem_wdata  out  32  RAM write data.
 mem_rdata  in  32  RAM combinational read data.
 gnt  out  2  current grant: 0 idle, 1 cpu, 2 display, 3 keyboard.
 drop_cnt  out  8  dropped-code count (present only with the macro, REQ-022).

Function
REQ-006 SHALL grant the RAM port once per cycle, with fixed priority CPU > display > keyboard.
REQ-007 SHALL grant the CPU whenever cpu_we or cpu_re is high and the address is not KB_STAT_ADDR; CPU accesses are never stalled.
REQ-008 SHALL return {31'b0, mbox_full} on cpu_rdata for reads of KB_STAT_ADDR, and mem_rdata otherwise.
REQ-009 SHALL ignore CPU writes to KB_STAT_ADDR.
REQ-010 SHALL push kb_code into the FIFO on a cycle where kb_valid and kb_ready are both high; kb_ready = FIFO not full.
REQ-011 SHALL, with the FIFO full and kb_valid high, drop the code and leave the FIFO unchanged.
REQ-012 SHALL, when not pre-empted, the FIFO is non-empty and mbox_full is 0, write {24'b0, head} to KB_DATA_ADDR, pop the FIFO and set mbox_full on the same edge; minimum latency is one cycle from push to RAM write.
REQ-013 SHALL clear mbox_full on a CPU read of KB_DATA_ADDR while mbox_full is 1; on a simultaneous push and pop, FIFO occupancy SHALL be unchanged.
REQ-014 SHALL set a pending-snapshot flag on a vsync rising edge (registered previous vsync).
REQ-015 SHALL, while the flag is pending and the CPU is not granted, read OFFSET_ADDR, load disp_offset from mem_rdata[9:0], set disp_valid and clear the flag on that edge.
REQ-016 SHALL leave the flag pending while pre-empted; a second vsync edge while pending SHALL NOT queue a second snapshot.
REQ-017 SHALL implement a registered scheduler FSM with states IDLE, CPU, DISP, KB that records the last grant and drives gnt; the RAM port signals SHALL be combinational from the current requests.
REQ-018 SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 in IDLE.

Reset
REQ-019 SHALL, when reset is low, asynchronously clear the FIFO (kb_ready=1), mbox_full, the pending flag and the registered previous vsync.
REQ-020 SHALL, when reset is low, asynchronously set disp_offset=0, disp_valid=0, gnt=0 and the FSM to IDLE.
REQ-021 SHALL discard an in-flight keyboard write or snapshot on reset, with no RAM write on the reset edge.

Configuration
REQ-022 SHALL, with MEM_ARB_DROP_CNT_EN defined, provide port drop_cnt, an 8-bit saturating counter (stops at 255) incremented per REQ-011 drop and cleared by reset.
REQ-023 SHALL, with MEM_ARB_DROP_CNT_EN defined, return drop_cnt in bits [15:8] of KB_STAT_ADDR reads.
REQ-024 SHALL, without MEM_ARB_DROP_CNT_EN, omit the drop_cnt port, omit the counter, and read bits [15:8] of the status word as 0.

Structure
REQ-025 SHALL place the address constants and the grant/state enum (IDLE, CPU, DISP, KB) in package mem_arb_pkg.
REQ-026 SHALL implement the FIFO as sub-module kb_fifo (push, pop, full, empty, head).

Verification
REQ-027 SHALL verify: kb_valid with code 8'h23, CPU idle -> RAM write of 32'h23 to word 1 one cycle later; status read returns 1.
REQ-028 SHALL verify: CPU writes 32'h15 to word 0 and vsync rises with the CPU busy for 3 cycles -> snapshot deferred, then disp_offset=10'h015 and disp_valid=1.
REQ-029 SHALL verify: 6 codes pushed with no CPU reads (depth 4) -> one code in the mailbox, 4 in the FIFO, 1 dropped; with the macro, drop_cnt=1.
REQ-030 SHALL verify: CPU read of word 1 in the same cycle as a push -> mbox_full clears and the next code is written on the following idle cycle.
REQ-031 SHALL verify: reset asserted mid keyboard write -> no mem_we, all outputs at reset values, kb_ready=1.
REQ-032 SHALL verify: CPU write to word 2 -> no RAM write; status word unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: grant/state encoding and default word map.
// Optional drop counter is enabled with MEM_ARB_DROP_CNT_EN.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int WORD_AW          = 5;
  localparam int DEF_OFFSET_ADDR  = 0;
  localparam int DEF_KB_DATA_ADDR = 1;
  localparam int DEF_KB_STAT_ADDR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DISP = 2'd2,
    KB   = 2'd3
  } grant_e;

  function automatic logic [WORD_AW-1:0] word_of(
    input logic [31:0] addr
  );
    return addr[6:2];
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Keyboard scancode FIFO: push ignored when full, pop ignored when empty.
// Part of mem_arbiter (MEM_ARB_DROP_CNT_EN has no effect here).
`timescale 1ns/1ps
module kb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop)  rd <= rd + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU > display snapshot > keyboard mailbox.
// Define MEM_ARB_DROP_CNT_EN to add the drop_cnt port and counter.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int OFFSET_ADDR  = DEF_OFFSET_ADDR,
  parameter int KB_DATA_ADDR = DEF_KB_DATA_ADDR,
  parameter int KB_STAT_ADDR = DEF_KB_STAT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_code,
  output logic        kb_ready,
  input  logic        vsync,
  output logic [9:0]  disp_offset,
  output logic        disp_valid,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  gnt
`ifdef MEM_ARB_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [4:0] OFF_W  = 5'(OFFSET_ADDR);
  localparam logic [4:0] DATA_W = 5'(KB_DATA_ADDR);
  localparam logic [4:0] STAT_W = 5'(KB_STAT_ADDR);

  logic [4:0] word;
  logic       stat_hit;
  logic       cpu_req;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic       mbox_full;
  logic       pend;
  logic       vs_q;
  logic       vs_rise;
  logic       mbox_clr;
  logic [7:0] stat_hi;
  logic       unused_addr;
  grant_e     grant;
  grant_e     state;

  assign word        = word_of(cpu_addr);
  assign stat_hit    = (word == STAT_W);
  assign cpu_req     = (cpu_we | cpu_re) & ~stat_hit;
  assign vs_rise     = vsync & ~vs_q;
  assign kb_ready    = ~fifo_full;
  assign gnt         = state;
  assign unused_addr = ^{cpu_addr[31:7], cpu_addr[1:0]};
  assign mbox_clr    = (grant == CPU) & cpu_re
                     & (word == DATA_W) & mbox_full;

  kb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kb_valid),
    .pop   (grant == KB),
    .din   (kb_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= grant;
  end

  // Holding grant at IDLE during reset keeps the RAM port quiet.
  always_comb begin
    grant     = IDLE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset)                        grant = IDLE;
    else if (cpu_req)                  grant = CPU;
    else if (pend)                     grant = DISP;
    else if (!fifo_empty && !mbox_full) grant = KB;
    unique case (grant)
      CPU: begin
        mem_we    = cpu_we;
        mem_addr  = word;
        mem_wdata = cpu_wdata;
      end
      DISP: begin
        mem_addr  = OFF_W;
      end
      KB: begin
        mem_we    = 1'b1;
        mem_addr  = DATA_W;
        mem_wdata = {24'b0, head};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mbox_full   <= 1'b0;
      pend        <= 1'b0;
      vs_q        <= 1'b0;
      disp_offset <= '0;
      disp_valid  <= 1'b0;
    end else begin
      vs_q <= vsync;
      if (grant == KB)   mbox_full <= 1'b1;
      else if (mbox_clr) mbox_full <= 1'b0;
      if (grant == DISP) begin
        pend        <= 1'b0;
        disp_offset <= mem_rdata[9:0];
        disp_valid  <= 1'b1;
      end else if (vs_rise) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (kb_valid && fifo_full
                 && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
  assign stat_hi = drop_cnt;
`else
  assign stat_hi = 8'h00;
`endif

  assign cpu_rdata = stat_hit
                   ? {16'h0, stat_hi, 7'h0, mbox_full}
                   : mem_rdata;

endmodule
